// File: rtl/pitch_if.sv
// Comparator-side and LED-side signals of the pitch classifier.
interface pitch_if #(
    parameter int CNT_W = 21
);
    logic             sig_in;
    logic [CNT_W-1:0] target_period;
    logic [3:0]       tone;
    logic             tone_valid;

    modport master (
        output sig_in,
        output target_period,
        input  tone,
        input  tone_valid
    );

    modport slave (
        input  sig_in,
        input  target_period,
        output tone,
        output tone_valid
    );
endinterface

// File: rtl/pitch_classifier.sv
// Period measurement, window averaging and flat/sharp
// classification of the squared-up guitar signal.
module pitch_classifier #(
    parameter int CNT_W      = 21,
    parameter int AVG_LOG2   = 2,
    parameter int MIN_PERIOD = 64,
    parameter int TIMEOUT    = 2000000
) (
    input  logic   clk,
    input  logic   rst_n,
    pitch_if.slave bus
);
    localparam int AW = CNT_W + AVG_LOG2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] EVAL    = 2'd2;

    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [AVG_LOG2-1:0] LAST = '1;

    logic                s1, s2, s_prev, edge_p;
    logic [CNT_W-1:0]    cnt;
    logic [AW-1:0]       acc;
    logic [AVG_LOG2-1:0] idx;
    logic [1:0]          state;
    logic                to_done;

    logic                accept, hit_to;
    logic [AW-1:0]       t_win, d;
    logic [AW:0]         diff, ndiff;
    logic [3:0]          tone_new;

    assign accept = edge_p && (cnt >= MIN_C);
    assign hit_to = (cnt == TO_C);

    assign t_win = AW'(bus.target_period) << AVG_LOG2;
    assign diff  = {1'b0, acc} - {1'b0, t_win};
    assign ndiff = {1'b0, t_win} - {1'b0, acc};
    assign d     = diff[AW] ? ndiff[AW-1:0] : diff[AW-1:0];

    // diff > 0 means the period is long, i.e. the note is flat
    always_comb begin
        tone_new = 4'd4;
        if (bus.target_period == '0)
            tone_new = 4'd0;
        else if (d <= (t_win >> 6))
            tone_new = 4'd4;
        else if (d <= (t_win >> 5))
            tone_new = diff[AW] ? 4'd5 : 4'd3;
        else if (d <= (t_win >> 4))
            tone_new = diff[AW] ? 4'd6 : 4'd2;
        else
            tone_new = diff[AW] ? 4'd7 : 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1             <= 1'b0;
            s2             <= 1'b0;
            s_prev         <= 1'b0;
            edge_p         <= 1'b0;
            cnt            <= '0;
            acc            <= '0;
            idx            <= '0;
            state          <= IDLE;
            to_done        <= 1'b0;
            bus.tone       <= 4'd0;
            bus.tone_valid <= 1'b0;
        end else begin
            s1             <= bus.sig_in;
            s2             <= s1;
            s_prev         <= s2;
            edge_p         <= s2 & ~s_prev;
            bus.tone_valid <= 1'b0;
            if (!hit_to)
                cnt <= cnt + ONE_C;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= ONE_C;
                        acc     <= '0;
                        idx     <= '0;
                        to_done <= 1'b0;
                        state   <= MEASURE;
                    end else if (hit_to && !to_done) begin
                        bus.tone       <= 4'd0;
                        bus.tone_valid <= 1'b1;
                        to_done        <= 1'b1;
                        acc            <= '0;
                    end
                end
                MEASURE: begin
                    if (hit_to) begin
                        bus.tone       <= 4'd0;
                        bus.tone_valid <= 1'b1;
                        to_done        <= 1'b1;
                        acc            <= '0;
                        idx            <= '0;
                        state          <= IDLE;
                    end else if (accept) begin
                        acc <= acc + AW'(cnt);
                        cnt <= ONE_C;
                        idx <= idx + 1'b1;
                        if (idx == LAST)
                            state <= EVAL;
                    end
                end
                EVAL: begin
                    bus.tone       <= tone_new;
                    bus.tone_valid <= 1'b1;
                    acc            <= '0;
                    idx            <= '0;
                    state          <= MEASURE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pitch_classifier.sv
// Directed-vector bench for pitch_classifier with a pulse scoreboard.
module tb_pitch_classifier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pitch_if #(.CNT_W(21)) bus ();

    pitch_classifier #(
        .CNT_W(21),
        .AVG_LOG2(2),
        .MIN_PERIOD(64),
        .TIMEOUT(5000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int         target;
        int         p0, p1, p2, p3;
        bit         glitch;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl [12];
    logic [3:0] expq [$];
    logic [3:0] e;
    int         vectors = 0;
    int         miscompares = 0;

    // every tone_valid pulse is matched against the next expected tone
    always @(negedge clk) begin
        if (rst_n && bus.tone_valid) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse tone=%0d required=no pulse",
                         bus.tone);
            end else begin
                e = expq.pop_front();
                if (bus.tone !== e) begin
                    miscompares++;
                    $display("FAIL window_tone got=%0d required=%0d",
                             bus.tone, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    // ends with a rising sig_in exactly p cycles after the previous one
    task automatic edge_after(input int p, input int tgt, input bit gl);
        for (int i = 1; i <= p; i++) begin
            @(negedge clk);
            if (i == 10) bus.sig_in = 1'b0;
            if (gl && i == 20) bus.sig_in = 1'b1;
            if (gl && i == 30) bus.sig_in = 1'b0;
            if (i == 20) bus.target_period = 21'(tgt);
            if (i == p) bus.sig_in = 1'b1;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1000, 1000, 1000, 1000, 1000, 1'b0, 4'd4};
        tbl[1]  = '{1000, 1000, 1000, 1000, 1000, 1'b0, 4'd4};
        tbl[2]  = '{1000, 1020, 1020, 1020, 1020, 1'b0, 4'd3};
        tbl[3]  = '{1000, 1050, 1050, 1050, 1050, 1'b0, 4'd2};
        tbl[4]  = '{1000, 1100, 1100, 1100, 1100, 1'b0, 4'd1};
        tbl[5]  = '{1000,  985,  985,  985,  985, 1'b0, 4'd4};
        tbl[6]  = '{1000,  960,  960,  960,  960, 1'b0, 4'd6};
        tbl[7]  = '{1000, 1015, 1015, 1016, 1016, 1'b0, 4'd4};
        tbl[8]  = '{1000, 1015, 1016, 1016, 1016, 1'b0, 4'd3};
        tbl[9]  = '{1000, 1000, 1000, 1000, 1000, 1'b1, 4'd4};
        tbl[10] = '{   0, 1000, 1000, 1000, 1000, 1'b0, 4'd0};
        tbl[11] = '{   0, 1000, 1000, 1000, 1000, 1'b0, 4'd0};

        bus.sig_in = 1'b0;
        bus.target_period = 21'd1000;
        repeat (3) @(negedge clk);
        check("reset_tone", int'(bus.tone), 0);
        check("reset_valid", int'(bus.tone_valid), 0);
        rst_n = 1'b1;

        repeat (100) @(negedge clk);
        bus.sig_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            expq.push_back(tbl[k].exp);
            edge_after(tbl[k].p0, tbl[k].target, tbl[k].glitch);
            edge_after(tbl[k].p1, tbl[k].target, tbl[k].glitch);
            edge_after(tbl[k].p2, tbl[k].target, tbl[k].glitch);
            edge_after(tbl[k].p3, tbl[k].target, tbl[k].glitch);
        end

        // signal disappears: one zero pulse, then silence
        expq.push_back(4'd0);
        repeat (10) @(negedge clk);
        bus.sig_in = 1'b0;
        repeat (6000) @(negedge clk);
        check("timeout_drain", expq.size(), 0);
        check("timeout_tone", int'(bus.tone), 0);

        bus.sig_in = 1'b1;
        for (int w = 0; w < 2; w++) begin
            expq.push_back(4'd4);
            for (int j = 0; j < 4; j++)
                edge_after(1000, 1000, 1'b0);
        end

        // reset two periods into a window
        edge_after(1000, 1000, 1'b0);
        edge_after(1000, 1000, 1'b0);
        check("pre_reset_tone", int'(bus.tone), 4);
        rst_n = 1'b0;
        #1;
        check("mid_reset_tone", int'(bus.tone), 0);
        check("mid_reset_valid", int'(bus.tone_valid), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        bus.sig_in = 1'b0;
        repeat (100) @(negedge clk);
        bus.sig_in = 1'b1;
        for (int j = 0; j < 3; j++)
            edge_after(1000, 1000, 1'b0);
        repeat (50) @(negedge clk);
        check("post_reset_4edges_tone", int'(bus.tone), 0);
        expq.push_back(4'd4);
        edge_after(1000, 1000, 1'b0);
        repeat (50) @(negedge clk);
        check("post_reset_5edges_tone", int'(bus.tone), 4);
        check("final_drain", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
